// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// arbitration state encoding and the priority-encode helper.
package irq_pkg;

    localparam logic [1:0] IRQ_IE   = 2'd0;
    localparam logic [1:0] IRQ_PEND = 2'd1;
    localparam logic [1:0] IRQ_MODE = 2'd2;
    localparam logic [1:0] IRQ_POL  = 2'd3;

    typedef enum logic {IDLE, REQ} state_e;

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[i] && !found) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side I/O bus of the interrupt controller: address, write data,
// strobes, and the read data / hit returned to the core's data mux.
interface irq_ctrl_if;
    logic [15:0] a;
    logic [7:0]  o;
    logic        w;
    logic        r;
    logic [7:0]  p;
    logic        hit;

    modport master (output a, o, w, r, input  p, hit);
    modport slave  (input  a, o, w, r, output p, hit);
endinterface

// File: rtl/irq_ctrl_chan.sv
// One request channel: 2-flop synchroniser, polarity, edge detect and the
// pending bit with set-over-clear priority.
module irq_chan (
    input  logic clock,
    input  logic reset_n,
    input  logic irq,
    input  logic mode,
    input  logic pol,
    input  logic pol_nxt,
    input  logic cfg_clr,
    input  logic clr,
    output logic pend
);
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic act_d_q, act_d_d;
    logic pend_q,  pend_d;
    logic act, rise;

    always_comb begin
        sync1_d = irq;
        sync2_d = sync1_q;
        act     = sync2_q ^ pol;
        rise    = act & ~act_d_q;
        // On a config write, preload the delayed copy with the post-write
        // value of act so the polarity flip itself never looks like an edge.
        act_d_d = cfg_clr ? (sync1_q ^ pol_nxt) : act;
        if (cfg_clr)
            pend_d = 1'b0;
        else if (mode)
            pend_d = rise | (pend_q & ~clr);
        else
            pend_d = act;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            act_d_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            act_d_q <= act_d_d;
            pend_q  <= pend_d;
        end
    end

    assign pend = pend_q;
endmodule

// File: rtl/irq_ctrl.sv
// I/O-mapped interrupt controller: register file, read mux, per-channel
// latching and lowest-index arbitration driving intr/vect to the core.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned CHANNELS = 8,
    parameter logic [15:0] BASE     = 16'h0058
) (
    input  logic                clock,
    input  logic                reset_n,
    irq_ctrl_if.slave           bus,
    input  logic [CHANNELS-1:0] irq,
    input  logic                ack,
    output logic                intr,
    output logic [2:0]          vect
);
    localparam logic [7:0] CH_MASK = 8'((16'd1 << CHANNELS) - 16'd1);

    logic [7:0] ie_q, ie_d, mode_q, mode_d, pol_q, pol_d;
    logic [7:0] pend_all, req, cfg_clr, w1c, ack_clr, clr;
    logic [1:0] sel;
    logic       wr, wr_ie, wr_pend, wr_mode, wr_pol;
    state_e     state_q, state_d;
    logic       intr_q, intr_d;
    logic [2:0] vect_q, vect_d;
    logic       unused_r;

    assign unused_r = bus.r;
    assign bus.hit  = (bus.a >= BASE) && (bus.a <= BASE + 16'd3);
    assign sel      = 2'(bus.a - BASE);

    always_comb begin
        wr      = bus.w & bus.hit;
        wr_ie   = wr && (sel == IRQ_IE);
        wr_pend = wr && (sel == IRQ_PEND);
        wr_mode = wr && (sel == IRQ_MODE);
        wr_pol  = wr && (sel == IRQ_POL);
        ie_d    = wr_ie   ? (bus.o & CH_MASK) : ie_q;
        mode_d  = wr_mode ? (bus.o & CH_MASK) : mode_q;
        pol_d   = wr_pol  ? (bus.o & CH_MASK) : pol_q;
        cfg_clr = (mode_d ^ mode_q) | (pol_d ^ pol_q);
        w1c     = wr_pend ? (bus.o & mode_q & CH_MASK) : '0;
        ack_clr = (state_q == REQ && ack) ? (8'd1 << vect_q) : '0;
        clr     = w1c | ack_clr;
        req     = pend_all & ie_q;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        irq_chan u_chan (
            .clock   (clock),
            .reset_n (reset_n),
            .irq     (irq[i]),
            .mode    (mode_q[i]),
            .pol     (pol_q[i]),
            .pol_nxt (pol_d[i]),
            .cfg_clr (cfg_clr[i]),
            .clr     (clr[i]),
            .pend    (pend_all[i])
        );
    end
    if (CHANNELS < 8) begin : g_pad
        assign pend_all[7:CHANNELS] = '0;
    end

    always_comb begin
        bus.p = '0;
        if (bus.hit) begin
            case (sel)
                IRQ_IE:   bus.p = ie_q;
                IRQ_PEND: bus.p = pend_all;
                IRQ_MODE: bus.p = mode_q;
                default:  bus.p = pol_q;
            endcase
        end
    end

    // Leaving REQ always passes through IDLE, giving the one idle cycle
    // between serviced requests.
    always_comb begin
        state_d = state_q;
        intr_d  = intr_q;
        vect_d  = vect_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = REQ;
                intr_d  = 1'b1;
                vect_d  = lowest_idx(req);
            end
            default: if (ack || !req[vect_q]) begin
                state_d = IDLE;
                intr_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ie_q    <= '0;
            mode_q  <= '0;
            pol_q   <= '0;
            state_q <= IDLE;
            intr_q  <= 1'b0;
            vect_q  <= '0;
        end else begin
            ie_q    <= ie_d;
            mode_q  <= mode_d;
            pol_q   <= pol_d;
            state_q <= state_d;
            intr_q  <= intr_d;
            vect_q  <= vect_d;
        end
    end

    assign intr = intr_q;
    assign vect = vect_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: an 8-channel instance for the functional
// sequence and a 3-channel instance for register masking.
module tb_irq_ctrl;
    localparam logic [15:0] BASE = 16'h0058;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] irq;
    logic       ack;
    logic       intr;
    logic [2:0] vect;
    logic [2:0] irq3;
    logic       ack3;
    logic       intr3;
    logic [2:0] vect3;
    logic [7:0] rdata;
    int         checks = 0;
    int         errors = 0;

    irq_ctrl_if bus8 ();
    irq_ctrl_if bus3 ();

    irq_ctrl #(.CHANNELS(8), .BASE(BASE)) u_dut (
        .clock(clock), .reset_n(reset_n), .bus(bus8),
        .irq(irq), .ack(ack), .intr(intr), .vect(vect)
    );

    irq_ctrl #(.CHANNELS(3), .BASE(BASE)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .bus(bus3),
        .irq(irq3), .ack(ack3), .intr(intr3), .vect(vect3)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] data);
        bus8.a = BASE + 16'(off);
        bus8.o = data;
        bus8.w = 1'b1;
        tick(1);
        bus8.w = 1'b0;
        bus8.a = 16'h0000;
    endtask

    task automatic rd(input logic [1:0] off, output logic [7:0] data);
        bus8.a = BASE + 16'(off);
        #1;
        data   = bus8.p;
        bus8.a = 16'h0000;
    endtask

    initial begin
        int waited;
        reset_n = 1'b0;
        irq     = 8'hFF;
        ack     = 1'b0;
        irq3    = '0;
        ack3    = 1'b0;
        bus8.a = '0; bus8.o = '0; bus8.w = 1'b0; bus8.r = 1'b0;
        bus3.a = '0; bus3.o = '0; bus3.w = 1'b0; bus3.r = 1'b0;

        // Reset with all request lines high
        tick(3);
        chk("rst_intr", {7'd0, intr}, 8'h00);
        chk("rst_vect", {5'd0, vect}, 8'h00);
        #1;
        chk("rst_p_outside", bus8.p, 8'h00);
        chk("rst_hit_outside", {7'd0, bus8.hit}, 8'h00);
        reset_n = 1'b1;
        tick(1);
        rd(2'd1, rdata);
        chk("pend_after_release", rdata, 8'h00);
        chk("intr_after_release", {7'd0, intr}, 8'h00);
        tick(5);
        rd(2'd1, rdata);
        chk("level_mirror_ff", rdata, 8'hFF);
        chk("intr_ie_zero", {7'd0, intr}, 8'h00);
        wr(2'd2, 8'hFF);
        rd(2'd1, rdata);
        chk("mode_write_clears", rdata, 8'h00);
        tick(5);
        rd(2'd1, rdata);
        chk("no_edge_after_mode", rdata, 8'h00);
        irq = 8'h00;
        tick(4);
        rd(2'd1, rdata);
        chk("falling_ignored_pol0", rdata, 8'h00);

        // Two edge requests, lowest index wins, then the other is serviced
        irq = 8'h20;
        tick(1);
        irq = 8'h04;
        tick(1);
        irq = 8'h00;
        tick(4);
        rd(2'd1, rdata);
        chk("pend_both", rdata, 8'h24);
        chk("intr_before_ie", {7'd0, intr}, 8'h00);
        wr(2'd0, 8'h24);
        chk("intr_ie_edge", {7'd0, intr}, 8'h00);
        tick(1);
        chk("intr_first", {7'd0, intr}, 8'h01);
        chk("vect_first", {5'd0, vect}, 8'h02);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("intr_after_ack", {7'd0, intr}, 8'h00);
        rd(2'd1, rdata);
        chk("pend_after_ack", rdata, 8'h20);
        tick(1);
        chk("intr_second", {7'd0, intr}, 8'h01);
        chk("vect_second", {5'd0, vect}, 8'h05);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        rd(2'd1, rdata);
        chk("pend_all_acked", rdata, 8'h00);
        chk("intr_all_acked", {7'd0, intr}, 8'h00);

        // Level channel 3
        wr(2'd0, 8'h00);
        wr(2'd2, 8'h00);
        wr(2'd0, 8'h08);
        irq = 8'h08;
        tick(3);
        chk("level_intr_3clk", {7'd0, intr}, 8'h00);
        tick(1);
        chk("level_intr_4clk", {7'd0, intr}, 8'h01);
        chk("level_vect", {5'd0, vect}, 8'h03);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("level_ack_idle", {7'd0, intr}, 8'h00);
        tick(1);
        chk("level_rereq", {7'd0, intr}, 8'h01);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(1);
        chk("level_rereq2", {7'd0, intr}, 8'h01);
        irq = 8'h00;
        waited = 0;
        while (intr !== 1'b0 && waited < 4) begin
            tick(1);
            waited++;
        end
        chk("level_release", {7'd0, intr}, 8'h00);
        rd(2'd1, rdata);
        chk("level_release_pend", rdata, 8'h00);

        // Falling-edge polarity on channel 0
        wr(2'd0, 8'h00);
        wr(2'd2, 8'hFF);
        wr(2'd3, 8'h01);
        tick(4);
        rd(2'd1, rdata);
        chk("pol_no_spurious", rdata, 8'h00);
        irq = 8'h01;
        tick(4);
        rd(2'd1, rdata);
        chk("pol_rise_ignored", rdata, 8'h00);
        irq = 8'h00;
        tick(2);
        rd(2'd1, rdata);
        chk("pol_fall_2clk", rdata, 8'h00);
        tick(1);
        rd(2'd1, rdata);
        chk("pol_fall_3clk", rdata, 8'h01);
        wr(2'd1, 8'h01);
        rd(2'd1, rdata);
        chk("w1c_clears", rdata, 8'h00);

        // Edge arriving together with a W1C on the same channel
        irq = 8'h02;
        tick(3);
        irq = 8'h00;
        tick(3);
        rd(2'd1, rdata);
        chk("ch1_pend", rdata, 8'h02);
        irq = 8'h02;
        tick(2);
        wr(2'd1, 8'h02);
        rd(2'd1, rdata);
        chk("set_beats_w1c", rdata, 8'h02);
        wr(2'd1, 8'h02);
        rd(2'd1, rdata);
        chk("w1c_after", rdata, 8'h00);
        irq = 8'h00;
        bus8.a = BASE + 16'd4;
        #1;
        chk("hit_base4", {7'd0, bus8.hit}, 8'h00);
        chk("p_base4", bus8.p, 8'h00);

        // Three-channel instance masks unused bits
        bus3.a = BASE;
        bus3.o = 8'hFF;
        bus3.w = 1'b1;
        tick(1);
        bus3.w = 1'b0;
        #1;
        chk("ch3_ie_mask", bus3.p, 8'h07);
        bus3.a = BASE + 16'd4;
        #1;
        chk("ch3_hit_base4", {7'd0, bus3.hit}, 8'h00);
        chk("ch3_p_base4", bus3.p, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
